// File: rtl/rv_isa_pkg.sv
// ============================================================================
//  Module      : rv_isa_pkg
//  Description : RV32I shared definitions (instruction classes, opcodes, NOP)
//                used by both the instruction encoder and decoder.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rv_isa_pkg;

    typedef enum logic [3:0] {
        CLS_LOAD   = 4'd0,
        CLS_STORE  = 4'd1,
        CLS_BRANCH = 4'd2,
        CLS_JALR   = 4'd3,
        CLS_JAL    = 4'd4,
        CLS_LUI    = 4'd5,
        CLS_AUIPC  = 4'd6,
        CLS_OP_IMM = 4'd7,
        CLS_OP     = 4'd8
    } instr_class_e;

    localparam logic [6:0] C_OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] C_OPC_STORE  = 7'b0100011;
    localparam logic [6:0] C_OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] C_OPC_JALR   = 7'b1100111;
    localparam logic [6:0] C_OPC_JAL    = 7'b1101111;
    localparam logic [6:0] C_OPC_LUI    = 7'b0110111;
    localparam logic [6:0] C_OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] C_OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] C_OPC_OP     = 7'b0110011;

    localparam logic [31:0] C_NOP_WORD = 32'h0000_0013;

    // True when v[31:lo] are all copies of one bit, i.e. v fits a (lo+1)-bit signed field.
    function automatic logic upper_is_sext(input logic [31:0] v, input int unsigned lo);
        logic [31:0] t;
        t = 32'($signed(v) >>> lo);
        return (t == '0) || (t == '1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/instr_pack.sv
// ============================================================================
//  Module      : instr_pack
//  Description : Combinational RV32I field packer with immediate range check.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_pack
    import rv_isa_pkg::*;
#(
    parameter logic [31:0] NOP_WORD = C_NOP_WORD
) (
    input  logic [3:0]  i_cls,
    input  logic [4:0]  i_rd,
    input  logic [4:0]  i_rs1,
    input  logic [4:0]  i_rs2,
    input  logic [2:0]  i_funct3,
    input  logic [6:0]  i_funct7,
    input  logic [31:0] i_imm,
    output logic [31:0] o_ir,
    output logic        o_err
);

    logic [31:0] w_ir;
    logic        w_ok;
    logic        w_shift;

    assign w_shift = (i_funct3 == 3'b001) || (i_funct3 == 3'b101);

    always_comb begin
        w_ir = '0;
        w_ok = 1'b1;
        case (i_cls)
            CLS_LOAD: begin
                w_ir = {i_imm[11:0], i_rs1, i_funct3, i_rd, C_OPC_LOAD};
                w_ok = upper_is_sext(i_imm, 11);
            end
            CLS_JALR: begin
                w_ir = {i_imm[11:0], i_rs1, i_funct3, i_rd, C_OPC_JALR};
                w_ok = upper_is_sext(i_imm, 11);
            end
            CLS_OP_IMM: begin
                // Shifts carry funct7 in the upper immediate bits and a 5-bit shamt.
                if (w_shift) begin
                    w_ir = {i_funct7, i_imm[4:0], i_rs1, i_funct3, i_rd, C_OPC_OP_IMM};
                    w_ok = (i_imm[31:5] == '0);
                end else begin
                    w_ir = {i_imm[11:0], i_rs1, i_funct3, i_rd, C_OPC_OP_IMM};
                    w_ok = upper_is_sext(i_imm, 11);
                end
            end
            CLS_STORE: begin
                w_ir = {i_imm[11:5], i_rs2, i_rs1, i_funct3, i_imm[4:0], C_OPC_STORE};
                w_ok = upper_is_sext(i_imm, 11);
            end
            CLS_BRANCH: begin
                w_ir = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, i_funct3,
                        i_imm[4:1], i_imm[11], C_OPC_BRANCH};
                w_ok = !i_imm[0] && upper_is_sext(i_imm, 12);
            end
            CLS_JAL: begin
                w_ir = {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12], i_rd, C_OPC_JAL};
                w_ok = !i_imm[0] && upper_is_sext(i_imm, 20);
            end
            CLS_LUI: begin
                w_ir = {i_imm[31:12], i_rd, C_OPC_LUI};
                w_ok = (i_imm[11:0] == '0);
            end
            CLS_AUIPC: begin
                w_ir = {i_imm[31:12], i_rd, C_OPC_AUIPC};
                w_ok = (i_imm[11:0] == '0);
            end
            CLS_OP: begin
                w_ir = {i_funct7, i_rs2, i_rs1, i_funct3, i_rd, C_OPC_OP};
            end
            default: begin
                w_ok = 1'b0;
            end
        endcase
    end

    assign o_err = !w_ok;
    assign o_ir  = w_ok ? w_ir : NOP_WORD;

endmodule

`default_nettype wire

// File: rtl/instr_encoder.sv
// ============================================================================
//  Module      : instr_encoder
//  Description : RV32I instruction encoder with valid/ready output register,
//                word-address counter and saturating illegal-request counter.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_encoder
    import rv_isa_pkg::*;
#(
    parameter int          ADDR_W   = 10,
    parameter logic [31:0] NOP_WORD = 32'h0000_0013
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_class,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [2:0]        in_funct3,
    input  logic [6:0]        in_funct7,
    input  logic [31:0]       in_imm,
    input  logic              addr_load,
    input  logic [ADDR_W-1:0] addr_init,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_ir,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_err,
    output logic [7:0]        err_count
);

    logic [31:0]       w_ir;
    logic              w_err;
    logic              w_accept;
    logic [ADDR_W-1:0] w_word_addr;

    logic              r_out_valid;
    logic [31:0]       r_out_ir;
    logic [ADDR_W-1:0] r_out_addr;
    logic              r_out_err;
    logic [7:0]        r_err_count;
    logic [ADDR_W-1:0] r_cnt;

    instr_pack #(
        .NOP_WORD (NOP_WORD)
    ) u_pack (
        .i_cls    (in_class),
        .i_rd     (in_rd),
        .i_rs1    (in_rs1),
        .i_rs2    (in_rs2),
        .i_funct3 (in_funct3),
        .i_funct7 (in_funct7),
        .i_imm    (in_imm),
        .o_ir     (w_ir),
        .o_err    (w_err)
    );

    assign in_ready    = !r_out_valid || out_ready;
    assign w_accept    = in_valid && in_ready;
    // A same-cycle load redirects the accepted word itself, not just the next one.
    assign w_word_addr = addr_load ? addr_init : r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_ir    <= '0;
            r_out_addr  <= '0;
            r_out_err   <= 1'b0;
            r_err_count <= '0;
            r_cnt       <= '0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_out_ir    <= w_ir;
            r_out_addr  <= w_word_addr;
            r_out_err   <= w_err;
            r_cnt       <= w_word_addr + ADDR_W'(1);
            if (w_err && (r_err_count != 8'hFF)) begin
                r_err_count <= r_err_count + 8'd1;
            end
        end else begin
            if (out_ready) begin
                r_out_valid <= 1'b0;
            end
            if (addr_load) begin
                r_cnt <= addr_init;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_ir    = r_out_ir;
    assign out_addr  = r_out_addr;
    assign out_err   = r_out_err;
    assign err_count = r_err_count;

endmodule

`default_nettype wire

// File: tb/tb_instr_encoder.sv
// ============================================================================
//  Module      : tb_instr_encoder
//  Description : Self-checking bench for instr_encoder with reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instr_encoder;

    localparam int ADDR_W = 10;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [3:0]        in_class;
    logic [4:0]        in_rd;
    logic [4:0]        in_rs1;
    logic [4:0]        in_rs2;
    logic [2:0]        in_funct3;
    logic [6:0]        in_funct7;
    logic [31:0]       in_imm;
    logic              addr_load;
    logic [ADDR_W-1:0] addr_init;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_ir;
    logic [ADDR_W-1:0] out_addr;
    logic              out_err;
    logic [7:0]        err_count;

    always #5 clk = ~clk;

    instr_encoder #(
        .ADDR_W   (ADDR_W),
        .NOP_WORD (32'h0000_0013)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_class  (in_class),
        .in_rd     (in_rd),
        .in_rs1    (in_rs1),
        .in_rs2    (in_rs2),
        .in_funct3 (in_funct3),
        .in_funct7 (in_funct7),
        .in_imm    (in_imm),
        .addr_load (addr_load),
        .addr_init (addr_init),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ir    (out_ir),
        .out_addr  (out_addr),
        .out_err   (out_err),
        .err_count (err_count)
    );

    typedef struct {
        bit [31:0] ir;
        int        addr;
        bit        err;
    } exp_t;

    exp_t q[$];
    int   m_cnt;
    int   m_ec;
    int   n_cmp;
    int   n_bad;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Encoding computed from the field rules with integer arithmetic and range tests.
    function automatic bit [31:0] ref_encode(input int cls, input int rd, input int rs1,
                                             input int rs2, input int f3, input int f7,
                                             input bit [31:0] imm, output bit err);
        int        s;
        bit [31:0] ir;
        s   = $signed(imm);
        err = 1'b0;
        ir  = '0;
        case (cls)
            0, 3: begin
                err = (s < -2048) || (s > 2047);
                ir  = ((s & 'hFFF) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | ((cls == 0) ? 3 : 103);
            end
            7: begin
                if (f3 == 1 || f3 == 5) begin
                    err = (imm > 31);
                    ir  = (f7 << 25) | ((imm & 31) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 19;
                end else begin
                    err = (s < -2048) || (s > 2047);
                    ir  = ((s & 'hFFF) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 19;
                end
            end
            1: begin
                err = (s < -2048) || (s > 2047);
                ir  = (((s >>> 5) & 127) << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12)
                    | ((s & 31) << 7) | 35;
            end
            2: begin
                err = ((s & 1) != 0) || (s < -4096) || (s > 4095);
                ir  = (((s >>> 12) & 1) << 31) | (((s >>> 5) & 63) << 25) | (rs2 << 20)
                    | (rs1 << 15) | (f3 << 12) | (((s >>> 1) & 15) << 8) | (((s >>> 11) & 1) << 7) | 99;
            end
            4: begin
                err = ((s & 1) != 0) || (s < -(1 << 20)) || (s > (1 << 20) - 1);
                ir  = (((s >>> 20) & 1) << 31) | (((s >>> 1) & 1023) << 21) | (((s >>> 11) & 1) << 20)
                    | (((s >>> 12) & 255) << 12) | (rd << 7) | 111;
            end
            5, 6: begin
                err = ((imm & 'hFFF) != 0);
                ir  = (imm & 32'hFFFF_F000) | (rd << 7) | ((cls == 5) ? 55 : 23);
            end
            8: begin
                ir = (f7 << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 51;
            end
            default: err = 1'b1;
        endcase
        return err ? 32'h0000_0013 : ir;
    endfunction

    // One clock: check in_ready, advance the model, then compare registered outputs.
    task automatic tick();
        bit        acc;
        bit        xfer;
        bit        e;
        int        a;
        exp_t      x;
        #1;
        if (!rst) check_eq("in_ready", in_ready, (q.size() == 0) || out_ready);
        if (rst) begin
            q.delete();
            m_cnt = 0;
            m_ec  = 0;
        end else begin
            acc  = in_valid && ((q.size() == 0) || out_ready);
            xfer = (q.size() != 0) && out_ready;
            if (xfer) void'(q.pop_front());
            if (acc) begin
                x.ir   = ref_encode(in_class, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm, e);
                x.err  = e;
                a      = addr_load ? int'(addr_init) : m_cnt;
                x.addr = a;
                q.push_back(x);
                m_cnt = (a + 1) % (1 << ADDR_W);
                if (e && m_ec < 255) m_ec++;
            end else if (addr_load) begin
                m_cnt = int'(addr_init);
            end
        end
        @(posedge clk);
        #1;
        check_eq("out_valid", out_valid, q.size() != 0);
        if (q.size() != 0) begin
            check_eq("out_ir", out_ir, q[0].ir);
            check_eq("out_addr", out_addr, q[0].addr);
            check_eq("out_err", out_err, q[0].err);
        end
        check_eq("err_count", err_count, m_ec);
    endtask

    task automatic set_req(input int cls, input int rd, input int rs1, input int rs2,
                           input int f3, input int f7, input bit [31:0] imm);
        in_valid  = 1'b1;
        in_class  = 4'(cls);
        in_rd     = 5'(rd);
        in_rs1    = 5'(rs1);
        in_rs2    = 5'(rs2);
        in_funct3 = 3'(f3);
        in_funct7 = 7'(f7);
        in_imm    = imm;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        addr_load = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        bit [31:0] held;
        bit [31:0] imm;
        n_cmp = 0;
        n_bad = 0;
        m_cnt = 0;
        m_ec  = 0;
        rst = 1'b1; in_valid = 1'b0; addr_load = 1'b0; addr_init = '0; out_ready = 1'b1;
        in_class = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_funct3 = '0; in_funct7 = '0; in_imm = '0;

        do_reset();
        check_eq("rst_out_ir", out_ir, 32'h0);
        check_eq("rst_out_addr", out_addr, 32'h0);
        check_eq("rst_out_err", out_err, 32'h0);

        set_req(7, 1, 0, 0, 0, 0, 5);
        tick();
        check_eq("addi", out_ir, 32'h0050_0093);
        check_eq("addi_addr", out_addr, 32'h0);
        check_eq("addi_err", out_err, 32'h0);

        do_reset();
        set_req(1, 0, 1, 2, 2, 0, 8);
        tick();
        check_eq("sw", out_ir, 32'h0020_A423);
        check_eq("sw_addr", out_addr, 32'h0);
        set_req(5, 5, 0, 0, 0, 0, 32'h1234_5000);
        tick();
        check_eq("lui", out_ir, 32'h1234_52B7);
        check_eq("lui_addr", out_addr, 32'h1);

        do_reset();
        set_req(4, 0, 0, 0, 0, 0, -4);
        tick();
        check_eq("jal", out_ir, 32'hFFDF_F06F);
        set_req(2, 0, 0, 0, 0, 0, 3);
        tick();
        check_eq("beq_odd_err", out_err, 32'h1);
        check_eq("beq_odd_nop", out_ir, 32'h0000_0013);
        check_eq("beq_odd_cnt", err_count, 32'h1);
        set_req(7, 1, 0, 0, 0, 0, 2048);
        tick();
        check_eq("addi_2048_err", out_err, 32'h1);
        set_req(7, 1, 1, 0, 1, 0, 33);
        tick();
        check_eq("slli_33_err", out_err, 32'h1);
        set_req(7, 1, 1, 0, 5, 7'h20, 3);
        tick();
        check_eq("srai", out_ir, 32'h4030_D093);

        out_ready = 1'b0;
        set_req(8, 3, 4, 5, 0, 0, 0);
        held = out_ir;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_eq("stall_ready", in_ready, 32'h0);
            check_eq("stall_hold", out_ir, held);
        end
        out_ready = 1'b1;
        tick();
        check_eq("release_add", out_ir, 32'h0052_01B3);
        in_valid = 1'b0;
        tick();

        do_reset();
        set_req(7, 1, 0, 0, 0, 0, 5);
        addr_load = 1'b1;
        addr_init = 10'd1023;
        tick();
        addr_load = 1'b0;
        check_eq("load_addr", out_addr, 32'd1023);
        tick();
        check_eq("wrap_addr", out_addr, 32'd0);

        rst = 1'b1; addr_load = 1'b1; addr_init = 10'd77;
        tick();
        rst = 1'b0; addr_load = 1'b0;
        tick();
        check_eq("rst_dominates_load", out_addr, 32'd0);

        set_req(9, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 300; i++) begin
            in_class = 4'($urandom_range(9, 15));
            tick();
        end
        check_eq("err_sat", err_count, 32'd255);

        do_reset();
        for (int i = 0; i < 3000; i++) begin
            case ($urandom_range(0, 4))
                0:       imm = 32'($urandom_range(0, 8191)) - 32'd4096;
                1:       imm = $urandom & 32'hFFFF_F000;
                2:       imm = 32'($urandom_range(0, 40));
                3:       imm = 32'($urandom_range(0, 1 << 21)) - 32'(1 << 20);
                default: imm = $urandom;
            endcase
            set_req(($urandom_range(0, 10) > 8) ? $urandom_range(9, 15) : $urandom_range(0, 8),
                    $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
                    $urandom_range(0, 7), $urandom_range(0, 127), imm);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            addr_load = ($urandom_range(0, 15) == 0);
            addr_init = ADDR_W'($urandom);
            rst       = ($urandom_range(0, 199) == 0);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
